// File: rtl/alu_bit_serial_ctrl_if.sv
// alu_bit_serial_ctrl_if: request/result bus of the bit-serial ALU sequencer
interface alu_bit_serial_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;
  modport master (output start, alu_ctrl, src_a, src_b,
                  input busy, done, result, zero, carry_out, overflow);
  modport slave (input start, alu_ctrl, src_a, src_b,
                 output busy, done, result, zero, carry_out, overflow);
endinterface

// File: rtl/alu_bit_serial_ctrl.sv
// alu_bit_serial_ctrl: runs a WIDTH-bit ALU op through an external 1-bit slice, LSB first; SLT_OVF_FIX_EN selects overflow-corrected slt
module alu_bit_serial_ctrl #(parameter int WIDTH = 8) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_bit_serial_ctrl_if.slave bus,
  output logic                 sl_a,
  output logic                 sl_b,
  output logic                 sl_less,
  output logic                 sl_ainvert,
  output logic                 sl_binvert,
  output logic [1:0]           sl_op,
  output logic                 sl_cin,
  input  logic                 sl_result,
  input  logic                 sl_cout,
  input  logic                 sl_set,
  input  logic                 sl_overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, sh, full, res_nx;
  logic [3:0]       ctrl;
  logic [CW-1:0]    idx;
  logic             cy, run, last, arith, logic_op, slt_bit;
  assign run      = state == RUN;
  assign last     = idx == CW'(WIDTH - 1);
  assign arith    = ctrl == 4'b0010 || ctrl == 4'b0110;
  assign logic_op = ctrl == 4'b0000 || ctrl == 4'b0001 || ctrl == 4'b1101 || ctrl == 4'b1100;
  assign full     = {sl_result, sh[WIDTH-1:1]};
`ifdef SLT_OVF_FIX_EN
  assign slt_bit  = sl_set ^ sl_overflow;
`else
  assign slt_bit  = sl_set;
`endif
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  // slice drive: only active while a bit is being processed
  always_comb begin
    sl_a       = run & a_q[idx];
    sl_b       = run & b_q[idx];
    sl_cin     = run & cy;
    sl_ainvert = run & ctrl[3];
    sl_binvert = run & ctrl[2];
    sl_op      = run ? ctrl[1:0] : 2'b00;
    sl_less    = 1'b0;
  end
  // next state and the result word formed on the final bit
  always_comb begin
    state_nx = state == IDLE ? (bus.start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
    res_nx   = ctrl == 4'b0111 ? {{(WIDTH-1){1'b0}}, slt_bit} :
               (arith || logic_op) ? full : '0;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // operand latch, bit shifting and end-of-op result/flag capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      sh            <= '0;
      ctrl          <= '0;
      idx           <= '0;
      cy            <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        a_q  <= bus.src_a;
        b_q  <= bus.src_b;
        ctrl <= bus.alu_ctrl;
        idx  <= '0;
        cy   <= bus.alu_ctrl[2];
      end
      if (run) begin
        sh  <= full;
        cy  <= sl_cout;
        idx <= idx + 1'b1;
      end
      if (run && last) begin
        bus.result    <= res_nx;
        bus.zero      <= res_nx == '0;
        bus.carry_out <= arith & sl_cout;
        bus.overflow  <= arith & sl_overflow;
      end
    end
  end
endmodule
